// File: rtl/fp_fma_arbiter.sv
// fp_fma_arbiter: shares one fused multiply-add pipeline between NUM_REQ requesters.
// Build option FP_FMA_ARB_FIXED_PRIO_EN selects strict lowest-index priority instead of round-robin.
module fp_fma_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FMA_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_in1,
  input  logic [NUM_REQ*32-1:0]  req_in2,
  input  logic [NUM_REQ*32-1:0]  req_in3,
  input  logic [NUM_REQ*3-1:0]   req_rm,
  output logic                   fma_valid_in,
  output logic [31:0]            fma_in1,
  output logic [31:0]            fma_in2,
  output logic [31:0]            fma_in3,
  output logic [2:0]             fma_rm,
  input  logic [31:0]            fma_out,
  input  logic [3:0]             fma_flags,
  input  logic                   fma_valid_out,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_data,
  output logic [3:0]             resp_flags,
  output logic                   seq_error
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int FLW = $clog2(FMA_LATENCY + 1);

  logic [IDW-1:0]         last_grant_q, last_grant_d;
  logic [IDW-1:0]         grant_id, cand;
  logic                   grant_found;
  logic [31:0]            sel_in1, sel_in2, sel_in3;
  logic [2:0]             sel_rm;
  logic                   fma_valid_q;
  logic [31:0]            in1_q, in2_q, in3_q;
  logic [2:0]             rm_q;
  logic [IDW-1:0]         id_q;
  logic [FMA_LATENCY-1:0] tag_v_q;
  logic [IDW-1:0]         tag_id_q [FMA_LATENCY];
  logic [NUM_REQ-1:0]     resp_valid_q;
  logic [31:0]            resp_data_q;
  logic [3:0]             resp_flags_q;
  logic                   seq_error_q;
  logic [FLW-1:0]         flush_q;
  logic                   head_v, late_result;
  logic [IDW-1:0]         head_id;

  // Handshake: a transfer happens on any cycle where req_valid[i] && req_ready[i];
  // req_ready is a combinational grant, so a requester must hold valid and operands until it sees ready.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FP_FMA_ARB_FIXED_PRIO_EN
      cand = IDW'(k);
`else
      cand = IDW'((int'(last_grant_q) + 1 + k) % NUM_REQ);
`endif
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
    if (rst) grant_found = 1'b0;
    req_ready = '0;
    if (grant_found) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    sel_in1 = '0;
    sel_in2 = '0;
    sel_in3 = '0;
    sel_rm  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == grant_id) begin
        sel_in1 = req_in1[i*32 +: 32];
        sel_in2 = req_in2[i*32 +: 32];
        sel_in3 = req_in3[i*32 +: 32];
        sel_rm  = req_rm[i*3 +: 3];
      end
    end
  end

`ifdef FP_FMA_ARB_FIXED_PRIO_EN
  assign last_grant_d = last_grant_q;
`else
  assign last_grant_d = grant_found ? grant_id : last_grant_q;
`endif

  assign head_v  = tag_v_q[FMA_LATENCY-1];
  assign head_id = tag_id_q[FMA_LATENCY-1];
  // Results issued before a reset can still drain out of the FMA for a few cycles; they meet empty tags.
  assign late_result = (flush_q != '0) && fma_valid_out && !head_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= IDW'(NUM_REQ - 1);
      fma_valid_q  <= 1'b0;
      in1_q        <= '0;
      in2_q        <= '0;
      in3_q        <= '0;
      rm_q         <= '0;
      id_q         <= '0;
      tag_v_q      <= '0;
      for (int k = 0; k < FMA_LATENCY; k++) tag_id_q[k] <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_flags_q <= '0;
      seq_error_q  <= 1'b0;
      flush_q      <= FLW'(FMA_LATENCY);
    end else begin
      last_grant_q <= last_grant_d;
      fma_valid_q  <= grant_found;
      if (grant_found) begin
        in1_q <= sel_in1;
        in2_q <= sel_in2;
        in3_q <= sel_in3;
        rm_q  <= sel_rm;
        id_q  <= grant_id;
      end
      for (int k = FMA_LATENCY - 1; k > 0; k--) begin
        tag_v_q[k]  <= tag_v_q[k-1];
        tag_id_q[k] <= tag_id_q[k-1];
      end
      tag_v_q[0]  <= fma_valid_q;
      tag_id_q[0] <= id_q;
      resp_valid_q <= '0;
      if (fma_valid_out && head_v) begin
        resp_valid_q[head_id] <= 1'b1;
        resp_data_q           <= fma_out;
        resp_flags_q          <= fma_flags;
      end
      if ((fma_valid_out != head_v) && !late_result) seq_error_q <= 1'b1;
      if (flush_q != '0) flush_q <= flush_q - FLW'(1);
    end
  end

  assign fma_valid_in = fma_valid_q;
  assign fma_in1      = in1_q;
  assign fma_in2      = in2_q;
  assign fma_in3      = in3_q;
  assign fma_rm       = rm_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_flags   = resp_flags_q;
  assign seq_error    = seq_error_q;
endmodule

// File: tb/tb_fp_fma_arbiter.sv
// Directed bench for fp_fma_arbiter: behavioural FMA stub with a fixed latency and an
// in-order response scoreboard that also checks the issue-to-response latency.
module tb_fp_fma_arbiter;
  localparam int N   = 4;
  localparam int LAT = 4;
  localparam int RW  = N + 36;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_in1, req_in2, req_in3;
  logic [N*3-1:0]  req_rm;
  logic            fma_valid_in;
  logic [31:0]     fma_in1, fma_in2, fma_in3;
  logic [2:0]      fma_rm;
  logic [31:0]     fma_out;
  logic [3:0]      fma_flags;
  logic            fma_valid_out;
  logic [N-1:0]    resp_valid;
  logic [31:0]     resp_data;
  logic [3:0]      resp_flags;
  logic            seq_error;

  logic [31:0]     op1 [N];
  logic [31:0]     op2 [N];
  logic [31:0]     op3 [N];
  logic [2:0]      op_rm [N];
  logic            force_vo = 1'b0;
  logic [LAT-1:0]  stub_v = '0;
  logic [31:0]     stub_d [LAT];
  logic [3:0]      stub_f [LAT];

  int              cyc = 0;
  int              n_checks = 0;
  int              n_fail = 0;
  logic [RW-1:0]   exp_q [$];
  int              due_q [$];

  fp_fma_arbiter #(.NUM_REQ(N), .FMA_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_in3(req_in3), .req_rm(req_rm),
    .fma_valid_in(fma_valid_in), .fma_in1(fma_in1), .fma_in2(fma_in2), .fma_in3(fma_in3),
    .fma_rm(fma_rm), .fma_out(fma_out), .fma_flags(fma_flags), .fma_valid_out(fma_valid_out),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_flags(resp_flags),
    .seq_error(seq_error)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- FMA stub ----------------
  function automatic logic [31:0] fma_stub(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [2:0] rm);
    if (a == 32'h4000_0000 && b == 32'h4040_0000 && c == 32'h3F80_0000 && rm == 3'b000)
      return 32'h40E0_0000;
    return a + b + c + {29'd0, rm};
  endfunction

  function automatic logic [3:0] flags_stub(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [2:0] rm);
    return {a[0], b[0], c[0], ^rm};
  endfunction

  always @(posedge clk) begin
    stub_v    <= {stub_v[LAT-2:0], fma_valid_in};
    stub_d[0] <= fma_stub(fma_in1, fma_in2, fma_in3, fma_rm);
    stub_f[0] <= flags_stub(fma_in1, fma_in2, fma_in3, fma_rm);
    for (int k = 1; k < LAT; k++) begin
      stub_d[k] <= stub_d[k-1];
      stub_f[k] <= stub_f[k-1];
    end
  end

  assign fma_valid_out = stub_v[LAT-1] | force_vo;
  assign fma_out       = stub_d[LAT-1];
  assign fma_flags     = stub_f[LAT-1];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_in1[i*32 +: 32] = op1[i];
      req_in2[i*32 +: 32] = op2[i];
      req_in3[i*32 +: 32] = op3[i];
      req_rm[i*3 +: 3]    = op_rm[i];
    end
  end

  // ---------------- checking / scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [RW-1:0] exp_entry(input int i);
    logic [N-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    return {oh, fma_stub(op1[i], op2[i], op3[i], op_rm[i]),
            flags_stub(op1[i], op2[i], op3[i], op_rm[i])};
  endfunction

  always @(negedge clk) begin
    if (resp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", {resp_valid, resp_data, resp_flags}, '0);
      end else begin
        check("resp", {resp_valid, resp_data, resp_flags}, exp_q.pop_front());
        check("resp_latency", cyc, due_q.pop_front());
      end
    end
    if (exp_q.size() > 0 && due_q[0] < cyc) begin
      check("resp_missing", cyc, due_q[0]);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; checks the grant of this cycle and advances one cycle.
  task automatic step_expect(input logic [N-1:0] exp_ready, input bit push);
    @(negedge clk);
    check("req_ready", req_ready, exp_ready);
    if (push) begin
      for (int i = 0; i < N; i++) begin
        if (exp_ready[i]) begin
          exp_q.push_back(exp_entry(i));
          due_q.push_back(cyc + LAT + 2);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step_expect('0, 1'b0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      op1[i]   = 32'h1111_0000 * 32'(i + 1);
      op2[i]   = 32'h0000_0100 * 32'(i + 3);
      op3[i]   = 32'h00A0_0001 + 32'(i);
      op_rm[i] = 3'(i + 1);
    end
    op1[2] = 32'h4000_0000;
    op2[2] = 32'h4040_0000;
    op3[2] = 32'h3F80_0000;
    op_rm[2] = 3'b000;

    // Reset state, with every requester asking: no grant may leak out during reset.
    rst = 1'b1;
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, '0);
    check("rst_fma_valid_in", fma_valid_in, 1'b0);
    check("rst_fma_in1", fma_in1, '0);
    check("rst_fma_rm", fma_rm, '0);
    check("rst_resp_valid", resp_valid, '0);
    check("rst_resp_data", resp_data, '0);
    check("rst_resp_flags", resp_flags, '0);
    check("rst_seq_error", seq_error, 1'b0);
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Single request from requester 2: 2.0*3.0+1.0 = 7.0.
    req_valid = 4'b0100;
    step_expect(4'b0100, 1'b1);
    req_valid = '0;
    @(negedge clk);
    check("issue_valid", fma_valid_in, 1'b1);
    check("issue_in1", fma_in1, 32'h4000_0000);
    check("issue_in2", fma_in2, 32'h4040_0000);
    check("issue_in3", fma_in3, 32'h3F80_0000);
    check("issue_rm", fma_rm, 3'b000);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("issue_idle_valid", fma_valid_in, 1'b0);
    check("issue_hold_in1", fma_in1, 32'h4000_0000);
    @(posedge clk);
    #1;
    idle(3);
    @(negedge clk);
    check("single_resp_valid", resp_valid, 4'b0100);
    check("single_resp_data", resp_data, 32'h40E0_0000);
    @(posedge clk);
    #1;
    idle(2);

    // All four requesters for eight cycles, starting from a fresh reset.
    apply_reset();
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
`ifdef FP_FMA_ARB_FIXED_PRIO_EN
      step_expect(4'b0001, 1'b1);
`else
      step_expect(4'(1 << (k % 4)), 1'b1);
`endif
    end

    // Requester 1 alone, then requester 3 joins.
    req_valid = 4'b0010;
    step_expect(4'b0010, 1'b1);
    req_valid = 4'b1010;
`ifdef FP_FMA_ARB_FIXED_PRIO_EN
    step_expect(4'b0010, 1'b1);
`else
    step_expect(4'b1000, 1'b1);
`endif
    step_expect(4'b0010, 1'b1);
    req_valid = '0;
    idle(10);
    check("drain_empty", exp_q.size(), 0);

    // Three transfers, reset two cycles later: those operations must vanish silently.
    req_valid = 4'b0111;
`ifdef FP_FMA_ARB_FIXED_PRIO_EN
    step_expect(4'b0001, 1'b0);
    step_expect(4'b0001, 1'b0);
    step_expect(4'b0001, 1'b0);
`else
    step_expect(4'b0100, 1'b0);
    step_expect(4'b0001, 1'b0);
    step_expect(4'b0010, 1'b0);
`endif
    req_valid = '0;
    idle(2);
    rst = 1'b1;
    #1;
    check("midrst_req_ready", req_ready, '0);
    check("midrst_fma_valid_in", fma_valid_in, 1'b0);
    check("midrst_fma_in1", fma_in1, '0);
    check("midrst_resp_valid", resp_valid, '0);
    check("midrst_resp_data", resp_data, '0);
    check("midrst_seq_error", seq_error, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(10);
    @(negedge clk);
    check("postrst_seq_error", seq_error, 1'b0);
    @(posedge clk);
    #1;

    // FMA result strobe with nothing in flight: sticky sequencing error.
    force_vo = 1'b1;
    @(posedge clk);
    #1 force_vo = 1'b0;
    @(negedge clk);
    check("seqerr_set", seq_error, 1'b1);
    check("seqerr_no_resp", resp_valid, '0);
    @(posedge clk);
    #1;
    idle(5);
    @(negedge clk);
    check("seqerr_sticky", seq_error, 1'b1);
    @(posedge clk);
    #1;
    apply_reset();
    @(negedge clk);
    check("seqerr_cleared", seq_error, 1'b0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
